// File: rtl/mem_sequencer.sv
// mem_sequencer
//   Multi-cycle sequencer that sits between a simple in-order core and a
//   single shared memory port. Each instruction runs as follows:
//     1. FETCH reads the instruction word at cpu_pc.
//     2. EXEC gives the core one cycle to decode it.
//     3. DATA runs an optional load/store access.
//     4. COMMIT pulses step so that the core retires the instruction.
//   Misaligned accesses and memory timeouts move the block into a FAULT
//   state. FAULT is terminal until reset.
//
// Parameters
//   TIMEOUT        wait cycles allowed for mem_ack before a bus fault (1..255)
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   cpu_pc         core program counter (fetch address)
//   cpu_load       decoded load flag for the instruction on inst
//   cpu_store      decoded store flag for the instruction on inst
//   cpu_address    core data address
//   cpu_store_data core store data
//   inst           latched instruction word
//   load_data      latched load result
//   step           commit enable; high for one cycle per instruction
//   mem_req        memory request
//   mem_we         memory write strobe
//   mem_addr       memory address
//   mem_wdata      memory write data
//   mem_rdata      memory read data, valid with mem_ack
//   mem_ack        memory completion; may arrive in the same cycle as mem_req
//   fault          sticky fault flag
//   fault_code     01 misaligned fetch, 10 misaligned data, 11 timeout
//   instret        count of retired instructions (wraps)
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_store_data,
  output logic [31:0] inst,
  output logic [31:0] load_data,
  output logic        step,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // The last wait count that is still tolerated. If there is no ack while the
  // counter holds this value, the count reaches TIMEOUT and the block faults.
  // An ack in that same cycle still wins.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_inst;
  logic [31:0] r_load_data;
  logic [31:0] r_instret;
  logic [7:0]  r_wait;
  logic        r_fault;
  logic [1:0]  r_fault_code;

  logic        w_mem_req;
  logic        w_mem_we;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_step;
  logic        w_latch_inst;
  logic        w_latch_load;
  logic        w_wait_clr;
  logic        w_wait_inc;
  logic        w_fault_set;
  logic [1:0]  w_fault_code;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, memory bus and datapath control decode
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = 32'd0;
    w_mem_wdata  = 32'd0;
    w_step       = 1'b0;
    w_latch_inst = 1'b0;
    w_latch_load = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_inc   = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_code = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
        w_wait_clr   = 1'b1;
      end
      S_FETCH: begin
        if (cpu_pc[1:0] != 2'b00) begin
          // A misaligned PC never reaches the bus.
          w_next_state = S_FAULT;
          w_fault_set  = 1'b1;
          w_fault_code = 2'b01;
        end else begin
          w_mem_req  = 1'b1;
          w_mem_addr = cpu_pc;
          if (mem_ack) begin
            w_latch_inst = 1'b1;
            w_next_state = S_EXEC;
          end else if (r_wait == TIMEOUT_LAST) begin
            w_next_state = S_FAULT;
            w_fault_set  = 1'b1;
            w_fault_code = 2'b11;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cpu_load || cpu_store) begin
          if (cpu_address[1:0] != 2'b00) begin
            w_next_state = S_FAULT;
            w_fault_set  = 1'b1;
            w_fault_code = 2'b10;
          end else begin
            w_next_state = S_DATA;
            w_wait_clr   = 1'b1;
          end
        end else begin
          w_next_state = S_COMMIT;
        end
      end
      S_DATA: begin
        w_mem_req  = 1'b1;
        w_mem_addr = cpu_address;
        w_mem_we   = cpu_store;
        if (cpu_store) begin
          w_mem_wdata = cpu_store_data;
        end else begin
          w_mem_wdata = 32'd0;
        end
        if (mem_ack) begin
          // A store takes priority on the bus, so only a pure load writes load_data.
          w_latch_load = cpu_load & ~cpu_store;
          w_next_state = S_COMMIT;
        end else if (r_wait == TIMEOUT_LAST) begin
          w_next_state = S_FAULT;
          w_fault_set  = 1'b1;
          w_fault_code = 2'b11;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_COMMIT: begin
        w_step       = 1'b1;
        w_next_state = S_FETCH;
        w_wait_clr   = 1'b1;
      end
      S_FAULT: begin
        w_next_state = S_FAULT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latched instruction, load data, retire counter, wait counter and fault status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inst       <= 32'd0;
      r_load_data  <= 32'd0;
      r_instret    <= 32'd0;
      r_wait       <= 8'd0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      if (w_latch_inst) begin
        r_inst <= mem_rdata;
      end
      if (w_latch_load) begin
        r_load_data <= mem_rdata;
      end
      if (w_step) begin
        r_instret <= r_instret + 32'd1;
      end
      if (w_wait_clr) begin
        r_wait <= 8'd0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_fault_set) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_fault_code;
      end
    end
  end

  // The bus outputs are decoded from the state register, so a reset drops
  // mem_req in the same instant that it forces IDLE.
  assign mem_req    = w_mem_req;
  assign mem_we     = w_mem_we;
  assign mem_addr   = w_mem_addr;
  assign mem_wdata  = w_mem_wdata;
  assign step       = w_step;
  assign inst       = r_inst;
  assign load_data  = r_load_data;
  assign instret    = r_instret;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer.
// The bench plays both the core and the memory. A transaction-level reference
// model works out the bus activity expected in every cycle of an instruction:
//   fetch for fetch_delay+1 cycles, one decode cycle,
//   then data for data_delay+1 cycles on a load/store,
//   then one commit cycle.
// The model also tracks the expected inst, load_data and instret values.
module tb_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_pc = 32'd0;
  logic        cpu_load = 1'b0;
  logic        cpu_store = 1'b0;
  logic [31:0] cpu_address = 32'd0;
  logic [31:0] cpu_store_data = 32'd0;
  logic [31:0] inst;
  logic [31:0] load_data;
  logic        step;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_instret = 32'd0;
  logic [31:0] m_load = 32'd0;

  mem_sequencer #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_pc(cpu_pc), .cpu_load(cpu_load), .cpu_store(cpu_store),
    .cpu_address(cpu_address), .cpu_store_data(cpu_store_data),
    .inst(inst), .load_data(load_data), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .fault(fault), .fault_code(fault_code), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Assert reset, check the cleared state, then release it during IDLE.
  task automatic do_reset();
    reset = 1'b0;
    mem_ack = 1'b0;
    @(negedge clock);
    #1;
    check_eq("rst_instret", instret, 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_load", load_data, 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_fcode", 32'(fault_code), 32'd0);
    check_eq("rst_step", 32'(step), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    m_instret = 32'd0;
    m_load = 32'd0;
    #1;
    check_eq("idle_req", 32'(mem_req), 32'd0);
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store. The caller must be at the start of a
  // FETCH cycle.
  task automatic run_instr(input logic [31:0] pc, input int kind, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] iword,
                           input logic [31:0] lword, input int fd, input int dd);
    cpu_pc = pc;
    cpu_load = (kind == 1);
    cpu_store = (kind == 2);
    cpu_address = addr;
    cpu_store_data = sdata;
    for (int k = 0; k <= fd; k++) begin
      @(negedge clock);
      mem_ack = (k == fd);
      mem_rdata = (k == fd) ? iword : $urandom;
      #1;
      if (k == 0) check_eq("instret", instret, m_instret);
      check_eq("f_req", 32'(mem_req), 32'd1);
      check_eq("f_we", 32'(mem_we), 32'd0);
      check_eq("f_addr", mem_addr, pc);
      check_eq("f_step", 32'(step), 32'd0);
    end
    // Decode cycle. A stray ack here must be ignored.
    @(negedge clock);
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check_eq("x_req", 32'(mem_req), 32'd0);
    check_eq("x_addr", mem_addr, 32'd0);
    check_eq("x_wdata", mem_wdata, 32'd0);
    check_eq("x_step", 32'(step), 32'd0);
    check_eq("x_inst", inst, iword);
    if (kind != 0) begin
      for (int k = 0; k <= dd; k++) begin
        @(negedge clock);
        mem_ack = (k == dd);
        mem_rdata = (k == dd) ? lword : $urandom;
        #1;
        check_eq("d_req", 32'(mem_req), 32'd1);
        check_eq("d_addr", mem_addr, addr);
        check_eq("d_we", 32'(mem_we), 32'(kind == 2));
        check_eq("d_wdata", mem_wdata, (kind == 2) ? sdata : 32'd0);
        check_eq("d_step", 32'(step), 32'd0);
      end
      if (kind == 1) m_load = lword;
    end
    // Commit cycle. Another stray ack must not disturb the latched values.
    @(negedge clock);
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check_eq("c_step", 32'(step), 32'd1);
    check_eq("c_req", 32'(mem_req), 32'd0);
    check_eq("c_inst", inst, iword);
    check_eq("c_load", load_data, m_load);
    check_eq("c_instret", instret, m_instret);
    m_instret = m_instret + 32'd1;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] ad;
    int kind;

    do_reset();
    // Zero-wait ALU instruction at address 0
    run_instr(32'h0, 0, 32'h0, 32'h0, 32'h00500093, 32'h0, 0, 0);
    // Load with the data ack delayed by two cycles
    run_instr(32'h4, 1, 32'h100, 32'h0, 32'h10002083, 32'hDEADBEEF, 0, 2);
    // Store: load_data must be left unchanged
    run_instr(32'h8, 2, 32'h104, 32'h12345678, 32'h10102223, 32'hCAFEF00D, 0, 0);
    // Ack arriving on the fourth wait cycle still completes normally
    run_instr(32'hC, 0, 32'h0, 32'h0, 32'h00000013, 32'h0, 3, 0);
    run_instr(32'h10, 1, 32'h200, 32'h0, 32'h20002083, 32'h55AA55AA, 0, 3);

    // Randomised instruction stream
    for (int n = 0; n < 40; n++) begin
      pc = {$urandom, 2'b00};
      ad = {$urandom, 2'b00};
      kind = $urandom_range(0, 2);
      run_instr(pc, kind, ad, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset asserted while a load waits in DATA
    cpu_pc = 32'h20; cpu_load = 1'b1; cpu_store = 1'b0; cpu_address = 32'h300;
    @(negedge clock); mem_ack = 1'b1; mem_rdata = 32'h1234;   // fetch
    @(negedge clock); mem_ack = 1'b0;                          // decode
    @(negedge clock); #1;                                      // data wait
    check_eq("dw_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_req", 32'(mem_req), 32'd0);
    check_eq("ar_instret", instret, 32'd0);
    check_eq("ar_step", 32'(step), 32'd0);
    do_reset();
    run_instr(32'h40, 0, 32'h0, 32'h0, 32'h00100113, 32'h0, 0, 0);

    // Fetch timeout: no ack for four cycles
    cpu_pc = 32'h44; cpu_load = 1'b0; cpu_store = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); mem_ack = 1'b0; #1;
      check_eq("to_req", 32'(mem_req), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); mem_ack = 1'($urandom_range(0, 1)); #1;
      check_eq("to_fault", 32'(fault), 32'd1);
      check_eq("to_code", 32'(fault_code), 32'd3);
      check_eq("to_req", 32'(mem_req), 32'd0);
      check_eq("to_step", 32'(step), 32'd0);
      check_eq("to_instret", instret, m_instret);
    end

    // Misaligned PC
    do_reset();
    cpu_pc = 32'h2;
    @(negedge clock); mem_ack = 1'b1; #1;
    check_eq("mpc_req", 32'(mem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      check_eq("mpc_fault", 32'(fault), 32'd1);
      check_eq("mpc_code", 32'(fault_code), 32'd1);
      check_eq("mpc_req", 32'(mem_req), 32'd0);
    end

    // Misaligned load address
    do_reset();
    cpu_pc = 32'h0; cpu_load = 1'b1; cpu_address = 32'h101;
    @(negedge clock); mem_ack = 1'b1; mem_rdata = 32'h10102083;
    @(negedge clock); mem_ack = 1'b0; #1;
    check_eq("mad_req", 32'(mem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      check_eq("mad_fault", 32'(fault), 32'd1);
      check_eq("mad_code", 32'(fault_code), 32'd2);
      check_eq("mad_req", 32'(mem_req), 32'd0);
      check_eq("mad_step", 32'(step), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles for mem_ack before a bus fault is raised (legal range 1..255).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cpu_pc  input  32  the core's current PC.
REQ-005 SHALL have port cpu_load / cpu_store  input  1 each  the core's decoded load/store flags for the instruction on inst.
REQ-006 SHALL have port cpu_address  input  32  the core's data address.
REQ-007 SHALL have port cpu_store_data  input  32  the core's store data.
REQ-008 SHALL have port inst  output  32  the latched instruction driven to the core.
REQ-009 SHALL have port load_data  output  32  the latched load result driven to the core.
REQ-010 SHALL have port step  output  1  the core's commit enable; the core updates the PC and register file only on an edge where step=1.
REQ-011 SHALL have port mem_req / mem_we  output  1 each  the shared memory request and write strobe.
REQ-012 SHALL have port mem_addr / mem_wdata  output  32 each  the shared memory address and write data.
REQ-013 SHALL have port mem_rdata  input  32  the memory read data, valid when mem_ack=1.
REQ-014 SHALL have port mem_ack  input  1  memory completion; may be asserted in the same cycle as mem_req.
REQ-015 SHALL have ports fault  output  1, fault_code  output  2, and instret  output  32  as defined below.

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC, DATA, COMMIT, FAULT, and SHALL leave IDLE for FETCH unconditionally on the first edge after reset release.
REQ-017 In FETCH it SHALL drive mem_req=1, mem_we=0, mem_addr=cpu_pc.
REQ-018 On mem_ack in FETCH it SHALL latch mem_rdata into inst and move to EXEC.
REQ-019 In EXEC, cpu_load|cpu_store=1 SHALL move to DATA; otherwise it SHALL move to COMMIT.
REQ-020 In DATA it SHALL drive mem_req=1, mem_addr=cpu_address, mem_we=cpu_store, and mem_wdata=cpu_store_data when storing (0 otherwise).
REQ-021 On mem_ack in DATA it SHALL latch mem_rdata into load_data when loading (load_data unchanged on store) and move to COMMIT.
REQ-022 step SHALL be 1 only in COMMIT, for exactly one cycle per instruction; COMMIT SHALL always move to FETCH.
REQ-023 instret SHALL increment by 1 on each COMMIT edge and wrap 0xFFFFFFFF to 0.
REQ-024 inst SHALL remain stable from the FETCH ack through the end of COMMIT.
REQ-025 mem_req, mem_addr, mem_we and mem_wdata SHALL be held stable while mem_req=1 and mem_ack=0.
REQ-026 Outside FETCH and DATA, mem_req, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-027 Zero-wait latency SHALL be 3 cycles per non-memory instruction (FETCH, EXEC, COMMIT) and 4 per load/store; each wait cycle adds 1.
REQ-028 An 8-bit wait counter SHALL clear on entry to FETCH or DATA and increment each cycle mem_req=1 with mem_ack=0.
REQ-029 When the wait counter reaches TIMEOUT with no ack, the block SHALL enter FAULT with fault_code=2'b11.
REQ-030 If cpu_pc[1:0]!=0 in FETCH, the block SHALL enter FAULT with fault_code=2'b01 without asserting mem_req.
REQ-031 If cpu_address[1:0]!=0 in EXEC with load or store, the block SHALL enter FAULT with fault_code=2'b10 without entering DATA.
REQ-032 FAULT SHALL be terminal until reset: fault=1, step=0, mem_req=0, and instret frozen.
REQ-033 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win (normal completion).
REQ-034 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-035 Reset assertion SHALL asynchronously force state=IDLE, and clear inst, load_data, instret, the wait counter, fault and fault_code to 0, with step=0 and mem_req=0.
REQ-036 Reset assertion mid-transaction SHALL drop mem_req immediately with no commit; after release, fetch SHALL restart from cpu_pc.

Verification
REQ-037 Zero-wait ADDI at cpu_pc=0x0 -> mem_req cycle 1 after IDLE, step high exactly 3 cycles after FETCH entry, instret=1.
REQ-038 LW, cpu_address=0x100, mem_rdata=0xDEADBEEF, ack delayed 2 cycles -> load_data=0xDEADBEEF at COMMIT, 6 cycles FETCH-to-COMMIT-exit.
REQ-039 SW, cpu_address=0x104, cpu_store_data=0x12345678 -> mem_we=1 with mem_wdata=0x12345678 only in DATA; load_data unchanged.
REQ-040 cpu_pc=0x2 -> fault=1, fault_code=01, mem_req never asserted; LW to 0x101 -> fault_code=10.
REQ-041 TIMEOUT=4, no ack -> FAULT after 4 wait cycles, fault_code=11; ack on the 4th cycle instead -> normal COMMIT.
REQ-042 Reset pulsed during DATA wait -> mem_req=0 immediately, instret=0, next fetch from cpu_pc.
